// File: rtl/mem_disp_pkg.sv
// Shared definitions for the memory display reader: read FSM encoding and default word width.
package mem_disp_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } rd_state_t;

endpackage

// File: rtl/mem_display_reader_dwell_timer.sv
// Auto-scan dwell timer: counts tick strobes while enabled and flags the tick that completes a dwell.
module dwell_timer #(
    parameter int DWELL_TICKS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tick,
    input  logic clr,
    output logic expire
);

    localparam int CW = $clog2(DWELL_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DWELL_TICKS - 1);

    logic [CW-1:0] count;

    // Expire coincides with the terminal tick so the reader can pop on the very next edge.
    assign expire = en & tick & (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && tick) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_display_reader.sv
// Drains the stack/queue memory one word at a time for the seven-segment display,
// advanced by a manual step pulse or a timed auto-scan.
//
// state   | meaning
// IDLE    | waiting for step or dwell expiry; samples empty
// POP     | pop strobe to memory for one cycle
// WAIT    | counting out the memory read latency
// CAPTURE | word captured, one more busy cycle before IDLE
module mem_display_reader
    import mem_disp_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RD_LAT      = 1,
    parameter int DWELL_TICKS = 1000,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              auto_en,
    input  logic              tick,
    input  logic              empty,
    input  logic [DATA_W-1:0] mem_out,
    output logic              pop,
    output logic [DATA_W-1:0] disp_value,
    output logic              disp_valid,
    output logic              no_data,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    rd_state_t       state;
    logic [LAT_W-1:0] lat_cnt;
    logic            dwell_expire;
    logic            req;

    dwell_timer #(
        .DWELL_TICKS(DWELL_TICKS)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .en     (auto_en & (state == ST_IDLE)),
        .tick   (tick),
        .clr    (~auto_en | step),
        .expire (dwell_expire)
    );

    assign req = step | dwell_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            pop        <= 1'b0;
            disp_value <= '0;
            disp_valid <= 1'b0;
            no_data    <= 1'b0;
            busy       <= 1'b0;
            rd_count   <= '0;
        end else begin
            pop     <= 1'b0;
            no_data <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (!empty) begin
                            state <= ST_POP;
                            pop   <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            no_data <= 1'b1;
                        end
                    end
                end
                ST_POP: begin
                    state   <= ST_WAIT;
                    lat_cnt <= LAT_W'(RD_LAT - 1);
                end
                ST_WAIT: begin
                    // Data is valid during the last WAIT cycle, so it is taken on entry to CAPTURE.
                    if (lat_cnt == '0) begin
                        state      <= ST_CAPTURE;
                        disp_value <= mem_out;
                        disp_valid <= 1'b1;
                        if (rd_count != '1) begin
                            rd_count <= rd_count + 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_display_reader.sv
// Self-checking bench for mem_display_reader with a queue-based memory and a word-order reference model.
module tb_mem_display_reader;

    localparam int DW    = 32;
    localparam int LAT   = 1;
    localparam int DWELL = 3;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          step;
    logic          auto_en;
    logic          tick;
    logic          empty = 1'b1;
    logic [DW-1:0] mem_out = '0;
    logic          pop;
    logic [DW-1:0] disp_value;
    logic          disp_valid;
    logic          no_data;
    logic          busy;
    logic [CW-1:0] rd_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] exp_q[$];
    int            pop_cyc[$];
    int            nd_cyc[$];

    mem_display_reader #(
        .DATA_W      (DW),
        .RD_LAT      (LAT),
        .DWELL_TICKS (DWELL),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .auto_en    (auto_en),
        .tick       (tick),
        .empty      (empty),
        .mem_out    (mem_out),
        .pop        (pop),
        .disp_value (disp_value),
        .disp_valid (disp_valid),
        .no_data    (no_data),
        .busy       (busy),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    // Memory with one cycle of read latency: data_out updates on the edge that samples pop.
    always @(posedge clk) begin
        if (pop === 1'b1) begin
            pop_cyc.push_back(cyc);
            if (mem_q.size() > 0) mem_out <= mem_q.pop_front();
        end
        if (no_data === 1'b1) nd_cyc.push_back(cyc);
        empty <= (mem_q.size() == 0);
        cyc <= cyc + 1;
    end

    function automatic int sat(int n);
        return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step = 1'b0; auto_en = 1'b0; tick = 1'b0;
        mem_q.delete();
        exp_q.delete();
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pop !== 1'b0) begin bad++; $display("FAIL reset_pop got=%b want=0", pop); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (disp_valid !== 1'b0 || no_data !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", disp_valid, no_data); end
        total++; if (disp_value !== '0) begin bad++; $display("FAIL reset_value got=%h want=0", disp_value); end
        total++; if (rd_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", rd_count); end
    endtask

    task automatic test_single_read();
        mem_q.push_back(32'hDEADBEEF);
        cycle(); cycle();
        step = 1'b1;
        cycle();
        step = 1'b0;
        total++; if (pop !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_pop got pop=%b busy=%b want 1 1", pop, busy); end
        cycle();
        total++; if (pop !== 1'b0 || disp_value !== '0) begin bad++; $display("FAIL single_wait got pop=%b val=%h want 0 0", pop, disp_value); end
        cycle();
        total++; if (disp_value !== 32'hDEADBEEF) begin bad++; $display("FAIL single_value got=%h want=deadbeef", disp_value); end
        total++; if (rd_count !== 2'd1 || disp_valid !== 1'b1) begin bad++; $display("FAIL single_count got cnt=%0d valid=%b want 1 1", rd_count, disp_valid); end
        cycle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_empty_step();
        int p0;
        p0 = pop_cyc.size();
        step = 1'b1;
        cycle();
        step = 1'b0;
        total++; if (no_data !== 1'b1 || pop !== 1'b0) begin bad++; $display("FAIL empty_nodata got nd=%b pop=%b want 1 0", no_data, pop); end
        cycle();
        total++; if (no_data !== 1'b0) begin bad++; $display("FAIL empty_pulse_width got=%b want=0", no_data); end
        total++; if (disp_value !== 32'hDEADBEEF || pop_cyc.size() != p0) begin bad++; $display("FAIL empty_hold got val=%h pops=%0d want deadbeef 0", disp_value, pop_cyc.size() - p0); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w1, w2;
        int p0;
        w1 = $urandom(); w2 = $urandom();
        mem_q.push_back(w1); mem_q.push_back(w2);
        cycle(); cycle();
        p0 = pop_cyc.size();
        step = 1'b1;
        cycle();
        cycle();
        step = 1'b0;
        repeat (6) cycle();
        total++; if (pop_cyc.size() - p0 != 1) begin bad++; $display("FAIL b2b_pops got=%0d want=1", pop_cyc.size() - p0); end
        total++; if (disp_value !== w1) begin bad++; $display("FAIL b2b_value got=%h want=%h", disp_value, w1); end
        total++; if (int'(rd_count) != sat(2)) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", rd_count, sat(2)); end
    endtask

    task automatic test_auto_scan();
        logic [DW-1:0] w[3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom();
            mem_q.push_back(w[i]);
        end
        cycle(); cycle();
        pop_cyc.delete(); nd_cyc.delete();
        auto_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick = ((i % 4) == 3);
            cycle();
        end
        tick = 1'b0; auto_en = 1'b0;
        cycle();
        total++;
        if (pop_cyc.size() != 3) begin
            bad++; $display("FAIL auto_pops got=%0d want=3", pop_cyc.size());
        end else begin
            total++; if (pop_cyc[1] - pop_cyc[0] != 12 || pop_cyc[2] - pop_cyc[1] != 12) begin
                bad++; $display("FAIL auto_spacing got=%0d,%0d want=12,12", pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
            end
            total++; if (nd_cyc.size() < 1) begin
                bad++; $display("FAIL auto_nodata got=0 pulses want>=1");
            end else if (nd_cyc[0] - pop_cyc[2] != 12) begin
                bad++; $display("FAIL auto_nodata_time got=%0d want=12", nd_cyc[0] - pop_cyc[2]);
            end
        end
        total++; if (disp_value !== w[2] || int'(rd_count) != sat(3)) begin bad++; $display("FAIL auto_last got val=%h cnt=%0d want %h %0d", disp_value, rd_count, w[2], sat(3)); end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] w1, w2;
        w1 = $urandom(); w2 = $urandom();
        mem_q.push_back(w1);
        cycle(); cycle();
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        total++; if (pop !== 1'b0 || busy !== 1'b0 || disp_valid !== 1'b0) begin bad++; $display("FAIL midrst_flags got pop=%b busy=%b valid=%b want 0 0 0", pop, busy, disp_valid); end
        total++; if (disp_value !== '0 || rd_count !== '0) begin bad++; $display("FAIL midrst_data got val=%h cnt=%0d want 0 0", disp_value, rd_count); end
        rst = 1'b0;
        cycle();
        mem_q.push_back(w2);
        cycle(); cycle();
        step = 1'b1;
        cycle();
        step = 1'b0;
        total++; if (pop !== 1'b1) begin bad++; $display("FAIL midrst_idle got pop=%b want=1", pop); end
        repeat (3) cycle();
        total++; if (disp_value !== w2 || rd_count !== 2'd1) begin bad++; $display("FAIL midrst_reread got val=%h cnt=%0d want %h 1", disp_value, rd_count, w2); end
    endtask

    task automatic test_random_saturation();
        logic [DW-1:0] w, exp_val;
        int exp_count, n0;
        logic exp_nd;
        do_reset();
        exp_count = 0;
        exp_val = '0;
        for (int i = 0; i < 14; i++) begin
            if (i < 5 || $urandom_range(0, 3) != 0) begin
                w = $urandom();
                mem_q.push_back(w);
                exp_q.push_back(w);
            end
            repeat ($urandom_range(2, 4)) cycle();
            n0 = nd_cyc.size();
            step = 1'b1;
            cycle();
            step = 1'b0;
            repeat (4) cycle();
            exp_nd = (exp_q.size() == 0);
            if (!exp_nd) begin
                exp_val = exp_q.pop_front();
                exp_count++;
            end
            total++; if (disp_value !== exp_val) begin bad++; $display("FAIL rand_value[%0d] got=%h want=%h", i, disp_value, exp_val); end
            total++; if (int'(rd_count) != sat(exp_count)) begin bad++; $display("FAIL rand_count[%0d] got=%0d want=%0d", i, rd_count, sat(exp_count)); end
            total++; if ((nd_cyc.size() != n0) != exp_nd) begin bad++; $display("FAIL rand_nodata[%0d] got=%0d want=%0d", i, nd_cyc.size() - n0, exp_nd); end
        end
    endtask

    initial begin
        rst = 1'b1; step = 1'b0; auto_en = 1'b0; tick = 1'b0;
        test_reset();
        test_single_read();
        test_empty_step();
        test_back_to_back();
        test_auto_scan();
        test_reset_mid_read();
        test_random_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
